melody_chime_poly: RTL and testbench
====================================

# melody_chime_poly

Parametrised polyphonic successor to the two-slot melody chime top. It generates the 10 µs and 1 ms timing strobes and dispatches note-on/note-off requests round-robin across `C_SLOT_N` external tone-generator slots. It also mixes their signed waveforms with saturation and drives a first-order 1-bit delta-sigma DAC with a complementary pin pair. It sits between the score sequencer and the per-slot tone generators / audio pins.

## Interface
- `C_SYS_CK_FREQ`, 48_000_000: system clock in Hz; must be a multiple of 100_000.
- `C_SLOT_N`, 4: number of tone slots, 2..8.
- `C_WAVE_W`, 16: width of each slot waveform, signed.
- `C_MIX_W`, 10: mixer/DAC sample width, 4..`C_WAVE_W`.
- `CK_i` in 1: system clock; single clock domain.
- `SRST_i` in 1: synchronous active-high reset.
- `NOTE_WE_i` in 1: note request strobe, one cycle.
- `NOTE_DIV_i` in 8: divider code (pitch) of the request.
- `NOTE_ON_i` in 1: 1 = note-on, 0 = note-off.
- `WAVES_i` in `C_SLOT_N*C_WAVE_W`: slot k waveform at bits `[k*C_WAVE_W +: C_WAVE_W]`, two's complement.
- `MUTE_i` in 1: force mixed sample to zero.
- `EE_10US_o` out 1: one-cycle strobe every 10 µs.
- `EE_1MS_o` out 1: one-cycle strobe every 1 ms.
- `SLOT_WE_o` out `C_SLOT_N`: per-slot write strobes.
- `SLOT_DIV_o` out 8: divider code for the written slot(s).
- `SLOT_ON_o` out 1: on/off flag for the written slot(s).
- `CLIP_o` out 1: one-cycle flag, mixer saturated.
- `AUDIO_L_o` out 1: DSM output.
- `AUDIO_R_o` out 1: complement of `AUDIO_L_o`.

## Operation
- **Tick generator**
  - Down-counter `L = C_SYS_CK_FREQ/100_000` reloads `L-1` at 0.
  - `EE_10US_o` is the registered value of (ctr == 0).
  - A 0..99 down-counter decrements on each wrap.
  - `EE_1MS_o` is the registered value of (ctr == 0 && ms_ctr == 0).
  - Both counters reset to 0.
- **Dispatcher** holds per-slot `active` bit, `div[7:0]` and a round-robin pointer `ptr`, all reset to 0.
- **Note-on**, slot chosen in this priority order:
  - (a) Retrigger: lowest-index active slot with `div == NOTE_DIV_i`; `ptr` unchanged.
  - (b) First inactive slot searching `ptr, ptr+1, ...` modulo N.
  - (c) Steal: slot `ptr`.
  - For (b) and (c), `ptr` becomes chosen+1 modulo N.
  - Chosen slot: `active`=1, `div`=`NOTE_DIV_i`.
- **Note-off**
  - Every active slot with `div == NOTE_DIV_i` is cleared to `active`=0 and strobed.
  - If no slot matches: no strobe, no state change.
- **Outputs** `SLOT_WE_o`, `SLOT_DIV_o` and `SLOT_ON_o` are registered.
  - `SLOT_WE_o` is all-zero except on the cycle after a strobe.
  - `SLOT_DIV_o` and `SLOT_ON_o` hold the last values.
- **Mixer**
  - Each slot contributes `WAVES_k >>> (C_WAVE_W-C_MIX_W)` (top `C_MIX_W` bits, arithmetic).
  - The sum is taken at width `C_MIX_W + ceil(log2(C_SLOT_N))`.
  - The sum is saturated to [`-2^(C_MIX_W-1)`, `2^(C_MIX_W-1)-1`] and registered into `mix`.
  - `CLIP_o` is registered with `mix` and is 1 when saturation applied.
  - With `MUTE_i`=1, `mix` is 0 and `CLIP_o` is 0.
- **DSM**
  - Convert to offset binary: `d = {~mix[msb], mix[msb-1:0]}`.
  - Accumulator `acc` is `C_MIX_W+1` bits: `acc <= {1'b0, acc[C_MIX_W-1:0]} + d`.
  - `AUDIO_L_o = acc[C_MIX_W]` and `AUDIO_R_o = ~acc[C_MIX_W]`; both are registers.
  - The ones-density of `AUDIO_L_o` equals `d/2^C_MIX_W`.

## Timing
- **Reset values:** all outputs 0 except `AUDIO_R_o`=1; `acc`=0, `mix`=0, `ptr`=0, all slots inactive.
- **Ticks:** the first `EE_10US_o` and `EE_1MS_o` occur together 1 cycle after reset release. After that, `EE_10US_o` has period L and `EE_1MS_o` has period 100·L.
- **Dispatch latency:** `NOTE_WE_i` at edge n produces `SLOT_WE_o` at edge n+1.
  - Back-to-back requests on consecutive cycles are each processed.
  - The second request sees state already updated by the first.
- **Audio latency:** `WAVES_i` at edge n is reflected in `mix`/`CLIP_o` at n+1 and reaches `acc`/`AUDIO_*` at n+2.
- **`SRST_i` priority:** `SRST_i` wins over every simultaneous input, including `NOTE_WE_i`.
  - Reset asserted mid-note clears all slot state; no `SLOT_WE_o` is emitted for the cleared slots.
  - External slots must be reset by the same `SRST_i`.
- **`MUTE_i` timing:** `MUTE_i` takes effect on `mix` at the next edge; the DSM keeps running at 50 % density.

## Test plan
- **Ticks:** `C_SYS_CK_FREQ`=1_000_000, release reset → `EE_10US_o` at cycle 1 then every 10 cycles; `EE_1MS_o` at cycle 1 then every 1000 cycles.
- **Allocation, N=4:**
  - Note-on div 10, 20, 30, 40, 50 on consecutive cycles → `SLOT_WE_o` = 0001, 0010, 0100, 1000, then 0001 (steal), with `SLOT_DIV_o`=50.
  - Then note-on 20 → 0010 (retrigger), `ptr` unchanged.
- **Note-off:**
  - Note-off 20 → `SLOT_WE_o`=0010, `SLOT_ON_o`=0.
  - Repeated note-off 20 → no strobe.
  - Next note-on 60 → slot 1 (first inactive from `ptr`=1).
- **Mixer saturation:**
  - N=4, W=10, all slots 16'h7FFF → `mix`=511, `CLIP_o`=1.
  - All 16'h8000 → `mix`=-512, `CLIP_o`=1.
  - Slots 16'h0080 and 16'hFF80, others 0 → `mix`=0, `CLIP_o`=0.
- **DSM density:**
  - `mix`=0 → `AUDIO_L_o` toggles 0/1 after settling (512/1024).
  - `mix`=511 → 1023 ones per 1024 cycles.
  - `AUDIO_R_o` == `~AUDIO_L_o` every cycle.
- **Reset mid-operation:** 3 slots active, assert `SRST_i` together with a note-on → no `SLOT_WE_o`; after release, note-on goes to slot 0; `AUDIO_L_o`=0, `AUDIO_R_o`=1 during reset.

Source files
------------

// File: rtl/melody_chime_poly.sv
// Polyphonic chime top: 10 us / 1 ms strobes, round-robin note dispatch to
// C_SLOT_N tone slots, saturating waveform mixer and 1-bit delta-sigma DAC.
module melody_chime_poly #(
    parameter int C_SYS_CK_FREQ = 48_000_000,
    parameter int C_SLOT_N      = 4,
    parameter int C_WAVE_W      = 16,
    parameter int C_MIX_W       = 10
) (
    input  logic                         CK_i,
    input  logic                         SRST_i,
    input  logic                         NOTE_WE_i,
    input  logic [7:0]                   NOTE_DIV_i,
    input  logic                         NOTE_ON_i,
    input  logic [C_SLOT_N*C_WAVE_W-1:0] WAVES_i,
    input  logic                         MUTE_i,
    output logic                         EE_10US_o,
    output logic                         EE_1MS_o,
    output logic [C_SLOT_N-1:0]          SLOT_WE_o,
    output logic [7:0]                   SLOT_DIV_o,
    output logic                         SLOT_ON_o,
    output logic                         CLIP_o,
    output logic                         AUDIO_L_o,
    output logic                         AUDIO_R_o
);

    localparam int L     = C_SYS_CK_FREQ / 100_000;
    localparam int CTR_W = (L > 1) ? $clog2(L) : 1;
    localparam int PTR_W = $clog2(C_SLOT_N);
    localparam int SUM_W = C_MIX_W + PTR_W;
    localparam int SHIFT = C_WAVE_W - C_MIX_W;

    localparam logic [CTR_W-1:0]        CTR_RELOAD = CTR_W'(L - 1);
    localparam logic signed [SUM_W-1:0] SUM_MAX    = SUM_W'((2 ** (C_MIX_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SUM_MIN    = SUM_W'(-(2 ** (C_MIX_W - 1)));
    localparam logic [C_MIX_W-1:0]      MIX_MAX    = {1'b0, {(C_MIX_W - 1){1'b1}}};
    localparam logic [C_MIX_W-1:0]      MIX_MIN    = {1'b1, {(C_MIX_W - 1){1'b0}}};

    logic [CTR_W-1:0] ctr;
    logic [6:0]       ms_ctr;

    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            ctr       <= '0;
            ms_ctr    <= '0;
            EE_10US_o <= 1'b0;
            EE_1MS_o  <= 1'b0;
        end else begin
            EE_10US_o <= (ctr == '0);
            EE_1MS_o  <= (ctr == '0) && (ms_ctr == '0);
            if (ctr == '0) begin
                ctr    <= CTR_RELOAD;
                ms_ctr <= (ms_ctr == '0) ? 7'd99 : ms_ctr - 7'd1;
            end else begin
                ctr <= ctr - CTR_W'(1);
            end
        end
    end

    logic [C_SLOT_N-1:0]        active;
    logic [C_SLOT_N-1:0][7:0]   div;
    logic [PTR_W-1:0]           ptr;

    logic [C_SLOT_N-1:0] match;
    logic [PTR_W-1:0]    hit_idx;
    logic                free_found;
    logic [PTR_W-1:0]    free_idx;
    logic [PTR_W-1:0]    scan_idx;
    logic [PTR_W-1:0]    sel_idx;
    logic [C_SLOT_N-1:0] we_next;
    logic [C_SLOT_N-1:0] active_next;
    logic [PTR_W-1:0]    ptr_next;

    // Slot choice for note-on: retrigger a matching slot, else first free from ptr, else steal ptr.
    always_comb begin
        match       = '0;
        hit_idx     = '0;
        free_found  = 1'b0;
        free_idx    = ptr;
        scan_idx    = '0;
        sel_idx     = ptr;
        we_next     = '0;
        active_next = active;
        ptr_next    = ptr;

        for (int k = 0; k < C_SLOT_N; k++) begin
            match[k] = active[k] && (div[k] == NOTE_DIV_i);
        end
        for (int k = C_SLOT_N - 1; k >= 0; k--) begin
            if (match[k]) hit_idx = PTR_W'(k);
        end
        for (int i = C_SLOT_N - 1; i >= 0; i--) begin
            scan_idx = PTR_W'((int'(ptr) + i) % C_SLOT_N);
            if (!active[scan_idx]) begin
                free_found = 1'b1;
                free_idx   = scan_idx;
            end
        end

        if (NOTE_WE_i) begin
            if (NOTE_ON_i) begin
                if (|match)          sel_idx = hit_idx;
                else if (free_found) sel_idx = free_idx;
                else                 sel_idx = ptr;
                we_next[sel_idx]     = 1'b1;
                active_next[sel_idx] = 1'b1;
                if (!(|match)) begin
                    ptr_next = (sel_idx == PTR_W'(C_SLOT_N - 1)) ? '0 : sel_idx + PTR_W'(1);
                end
            end else begin
                we_next     = match;
                active_next = active & ~match;
            end
        end
    end

    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            active     <= '0;
            div        <= '0;
            ptr        <= '0;
            SLOT_WE_o  <= '0;
            SLOT_DIV_o <= '0;
            SLOT_ON_o  <= 1'b0;
        end else begin
            active    <= active_next;
            ptr       <= ptr_next;
            SLOT_WE_o <= we_next;
            if (|we_next) begin
                SLOT_DIV_o <= NOTE_DIV_i;
                SLOT_ON_o  <= NOTE_ON_i;
            end
            for (int k = 0; k < C_SLOT_N; k++) begin
                if (we_next[k] && NOTE_ON_i) div[k] <= NOTE_DIV_i;
            end
        end
    end

    logic [SUM_W-1:0]   sum;
    logic [C_MIX_W-1:0] sat_mix;
    logic               sat_clip;
    logic [C_MIX_W-1:0] mix;
    logic               unused_wave_lsbs;

    assign unused_wave_lsbs = ^WAVES_i;

    // Each slot contributes its top C_MIX_W bits, sign-extended to the widened sum.
    always_comb begin
        sum = '0;
        for (int k = 0; k < C_SLOT_N; k++) begin
            sum = sum + {{PTR_W{WAVES_i[k*C_WAVE_W + C_WAVE_W - 1]}},
                         WAVES_i[k*C_WAVE_W + SHIFT +: C_MIX_W]};
        end
        sat_clip = 1'b0;
        sat_mix  = sum[C_MIX_W-1:0];
        if ($signed(sum) > SUM_MAX) begin
            sat_mix  = MIX_MAX;
            sat_clip = 1'b1;
        end else if ($signed(sum) < SUM_MIN) begin
            sat_mix  = MIX_MIN;
            sat_clip = 1'b1;
        end
    end

    always_ff @(posedge CK_i) begin
        if (SRST_i || MUTE_i) begin
            mix    <= '0;
            CLIP_o <= 1'b0;
        end else begin
            mix    <= sat_mix;
            CLIP_o <= sat_clip;
        end
    end

    logic [C_MIX_W-1:0] dsm_in;
    logic [C_MIX_W:0]   acc;
    logic [C_MIX_W:0]   acc_next;

    // Offset-binary sample feeds a carry-out accumulator; the carry is the 1-bit stream.
    assign dsm_in   = {~mix[C_MIX_W-1], mix[C_MIX_W-2:0]};
    assign acc_next = {1'b0, acc[C_MIX_W-1:0]} + {1'b0, dsm_in};
    assign AUDIO_L_o = acc[C_MIX_W];

    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            acc       <= '0;
            AUDIO_R_o <= 1'b1;
        end else begin
            acc       <= acc_next;
            AUDIO_R_o <= ~acc_next[C_MIX_W];
        end
    end

endmodule

// File: tb/tb_melody_chime_poly.sv
// Bench for melody_chime_poly: spec-level reference model compared every cycle,
// plus directed note/mixer/DSM/reset scenarios with hand-computed literals.
module tb_melody_chime_poly;

    localparam int N    = 4;
    localparam int WW   = 16;
    localparam int MW   = 10;
    localparam int FREQ = 1_000_000;
    localparam int L    = FREQ / 100_000;

    logic            CK_i       = 1'b0;
    logic            SRST_i     = 1'b1;
    logic            NOTE_WE_i  = 1'b0;
    logic [7:0]      NOTE_DIV_i = '0;
    logic            NOTE_ON_i  = 1'b0;
    logic [N*WW-1:0] WAVES_i    = '0;
    logic            MUTE_i     = 1'b0;
    logic            EE_10US_o;
    logic            EE_1MS_o;
    logic [N-1:0]    SLOT_WE_o;
    logic [7:0]      SLOT_DIV_o;
    logic            SLOT_ON_o;
    logic            CLIP_o;
    logic            AUDIO_L_o;
    logic            AUDIO_R_o;

    melody_chime_poly #(
        .C_SYS_CK_FREQ(FREQ),
        .C_SLOT_N     (N),
        .C_WAVE_W     (WW),
        .C_MIX_W      (MW)
    ) dut (
        .CK_i      (CK_i),
        .SRST_i    (SRST_i),
        .NOTE_WE_i (NOTE_WE_i),
        .NOTE_DIV_i(NOTE_DIV_i),
        .NOTE_ON_i (NOTE_ON_i),
        .WAVES_i   (WAVES_i),
        .MUTE_i    (MUTE_i),
        .EE_10US_o (EE_10US_o),
        .EE_1MS_o  (EE_1MS_o),
        .SLOT_WE_o (SLOT_WE_o),
        .SLOT_DIV_o(SLOT_DIV_o),
        .SLOT_ON_o (SLOT_ON_o),
        .CLIP_o    (CLIP_o),
        .AUDIO_L_o (AUDIO_L_o),
        .AUDIO_R_o (AUDIO_R_o)
    );

    always #5 CK_i = ~CK_i;

    int checks = 0;
    int errors = 0;
    bit checkEnable = 1'b0;

    // Reference model state, advanced once per rising edge
    int       t;
    bit       mEe10, mEe1ms;
    bit [N-1:0] mWe;
    bit [7:0] mDiv;
    bit       mOn;
    int       mMix;
    bit       mClip;
    int       accLow;
    bit       mAudio;
    bit       mActive [N];
    int       mSlotDiv[N];
    int       mPtr;

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelStep();
        int sel, sum, c;
        bit found;
        logic signed [WW-1:0] w;
        if (SRST_i) begin
            t = 0; mEe10 = 0; mEe1ms = 0; mWe = '0; mDiv = '0; mOn = 0;
            mMix = 0; mClip = 0; accLow = 0; mAudio = 0; mPtr = 0;
            for (int k = 0; k < N; k++) begin mActive[k] = 0; mSlotDiv[k] = 0; end
        end else begin
            t++;
            mEe10  = ((t - 1) % L == 0);
            mEe1ms = ((t - 1) % (100 * L) == 0);

            sum    = accLow + mMix + (1 << (MW - 1));
            mAudio = (sum >= (1 << MW));
            accLow = sum % (1 << MW);

            if (MUTE_i) begin
                mMix = 0; mClip = 0;
            end else begin
                sum = 0;
                for (int k = 0; k < N; k++) begin
                    w = WAVES_i[k*WW +: WW];
                    c = int'(w);
                    sum += (c >>> (WW - MW));
                end
                mClip = 0;
                if (sum > 511) begin mMix = 511; mClip = 1; end
                else if (sum < -512) begin mMix = -512; mClip = 1; end
                else mMix = sum;
            end

            mWe = '0;
            if (NOTE_WE_i && NOTE_ON_i) begin
                found = 0; sel = 0;
                for (int k = 0; k < N; k++)
                    if (!found && mActive[k] && mSlotDiv[k] == NOTE_DIV_i) begin found = 1; sel = k; end
                if (!found) begin
                    sel = mPtr;
                    for (int i = 0; i < N; i++)
                        if (!found && !mActive[(mPtr + i) % N]) begin found = 1; sel = (mPtr + i) % N; end
                    mPtr = (sel + 1) % N;
                end
                mActive[sel] = 1; mSlotDiv[sel] = NOTE_DIV_i; mWe[sel] = 1'b1;
            end else if (NOTE_WE_i) begin
                for (int k = 0; k < N; k++)
                    if (mActive[k] && mSlotDiv[k] == NOTE_DIV_i) begin mActive[k] = 0; mWe[k] = 1'b1; end
            end
            if (mWe != '0) begin mDiv = NOTE_DIV_i; mOn = NOTE_ON_i; end
        end
    endtask

    initial forever begin
        @(posedge CK_i);
        modelStep();
        checkEnable = 1'b1;
    end

    initial forever begin
        @(negedge CK_i);
        if (checkEnable) begin
            checkOutput("ee10us", EE_10US_o, mEe10);
            checkOutput("ee1ms", EE_1MS_o, mEe1ms);
            checkOutput("slot_we", SLOT_WE_o, mWe);
            checkOutput("slot_div", SLOT_DIV_o, mDiv);
            checkOutput("slot_on", SLOT_ON_o, mOn);
            checkOutput("mix", $signed(dut.mix), mMix);
            checkOutput("clip", CLIP_o, mClip);
            checkOutput("audio_l", AUDIO_L_o, mAudio);
            checkOutput("audio_r", AUDIO_R_o, !mAudio);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic we, input logic on, input logic [7:0] divCode);
        @(negedge CK_i);
        NOTE_WE_i  = we;
        NOTE_ON_i  = on;
        NOTE_DIV_i = divCode;
    endtask

    task automatic countOnes(input int cycles, output int ones);
        ones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CK_i);
            if (AUDIO_L_o === 1'b1) ones++;
        end
    endtask

    initial begin
        int n, m, ones;
        repeat (3) @(negedge CK_i);
        checkOutput("reset_audio_r", AUDIO_R_o, 1);
        checkOutput("reset_slot_we", SLOT_WE_o, 0);
        SRST_i = 1'b0;

        @(negedge CK_i);
        checkOutput("first_ee10us", EE_10US_o, 1);
        checkOutput("first_ee1ms", EE_1MS_o, 1);
        n = 0;
        do begin @(negedge CK_i); n++; end while (EE_10US_o !== 1'b1 && n < 20);
        checkOutput("ee10us_period", n, 10);
        m = n;
        while (EE_1MS_o !== 1'b1 && m < 1100) begin @(negedge CK_i); m++; end
        checkOutput("ee1ms_period", m, 1000);

        applyStimulus(1, 1, 8'd10);
        applyStimulus(1, 1, 8'd20);  checkOutput("alloc_10", SLOT_WE_o, 4'b0001);
        applyStimulus(1, 1, 8'd30);  checkOutput("alloc_20", SLOT_WE_o, 4'b0010);
        applyStimulus(1, 1, 8'd40);  checkOutput("alloc_30", SLOT_WE_o, 4'b0100);
        applyStimulus(1, 1, 8'd50);  checkOutput("alloc_40", SLOT_WE_o, 4'b1000);
        applyStimulus(1, 1, 8'd20);  checkOutput("steal_50", SLOT_WE_o, 4'b0001);
                                     checkOutput("steal_div", SLOT_DIV_o, 50);
        applyStimulus(1, 0, 8'd20);  checkOutput("retrig_20", SLOT_WE_o, 4'b0010);
        applyStimulus(1, 0, 8'd20);  checkOutput("off_20", SLOT_WE_o, 4'b0010);
                                     checkOutput("off_20_on", SLOT_ON_o, 0);
        applyStimulus(1, 1, 8'd60);  checkOutput("off_20_again", SLOT_WE_o, 4'b0000);
        applyStimulus(1, 0, 8'd40);  checkOutput("on_60_slot1", SLOT_WE_o, 4'b0010);
                                     checkOutput("on_60_div", SLOT_DIV_o, 60);
        applyStimulus(0, 0, 8'd0);   checkOutput("off_40", SLOT_WE_o, 4'b1000);

        WAVES_i = {N{16'h7FFF}};
        applyStimulus(0, 0, 8'd0);
        checkOutput("mix_pos_sat", $signed(dut.mix), 511);
        checkOutput("clip_pos", CLIP_o, 1);
        countOnes(1024, ones);
        checkOutput("dsm_511_density", ones, 1023);

        MUTE_i = 1'b1;
        applyStimulus(0, 0, 8'd0);
        checkOutput("mute_mix", $signed(dut.mix), 0);
        checkOutput("mute_clip", CLIP_o, 0);
        MUTE_i = 1'b0;
        WAVES_i = {N{16'h8000}};
        applyStimulus(0, 0, 8'd0);
        checkOutput("mix_neg_sat", $signed(dut.mix), -512);
        checkOutput("clip_neg", CLIP_o, 1);

        WAVES_i = {16'h0000, 16'h0000, 16'hFF80, 16'h0080};
        applyStimulus(0, 0, 8'd0);
        checkOutput("mix_cancel", $signed(dut.mix), 0);
        checkOutput("clip_cancel", CLIP_o, 0);
        countOnes(1024, ones);
        checkOutput("dsm_zero_density", ones, 512);

        applyStimulus(1, 1, 8'd70);
        SRST_i = 1'b1;
        applyStimulus(0, 0, 8'd0);
        checkOutput("rst_no_we", SLOT_WE_o, 4'b0000);
        checkOutput("rst_audio_l", AUDIO_L_o, 0);
        checkOutput("rst_audio_r", AUDIO_R_o, 1);
        applyStimulus(1, 1, 8'd80);
        SRST_i = 1'b0;
        applyStimulus(0, 0, 8'd0);
        checkOutput("post_rst_slot0", SLOT_WE_o, 4'b0001);
        checkOutput("post_rst_div", SLOT_DIV_o, 80);

        repeat (4) @(negedge CK_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
